hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Producer-side companion to the EX-stage bypass logic in the pipelined RV32I core.
- Tracks every in-flight register write, per architectural register, from the moment the instruction leaves ID.
- Raises a stall when an instruction in ID reads a register whose value will not yet be forwardable when that instruction reaches EX. This covers load-use and multi-cycle producers.
- Sits beside the ID/EX pipeline register; drives the PC/IF-ID enables and the ID/EX bubble insert.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- LAT_W, 2, width of the per-register countdown and of i_id_lat.
- STALL_THR, 1, stall when the countdown is strictly greater than this value. 1 means the EX/MEM bypass is the youngest forwarding source.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_id_valid  in  1  ID holds a valid instruction.
- i_id_rs1  in  5  source register 1 of the ID instruction.
- i_id_rs2  in  5  source register 2 of the ID instruction.
- i_id_rs1_used  in  1  rs1 is actually read.
- i_id_rs2_used  in  1  rs2 is actually read.
- i_id_rd  in  5  destination register.
- i_id_regwrite  in  1  the instruction writes rd.
- i_id_lat  in  LAT_W  cycles after entering EX until the result is forwardable: 1 ALU, 2 load, larger for multi-cycle; 0 means untracked.
- i_flush  in  1  kill the ID instruction (branch or jump resolved in EX).
- i_hold  in  1  global backend freeze.
- o_stall  out  1  freeze PC and IF/ID, insert a bubble into ID/EX.
- o_issue  out  1  the ID instruction advances into EX this cycle.
- o_busy  out  NREG  bit r is set when cnt[r] != 0.

Behaviour:
- State: cnt[r] (LAT_W bits) for r = 1..NREG-1; cnt[0] is constant 0.
- Reset (async, i_rst_n = 0): all cnt = 0, so o_busy = 0, o_stall = 0, o_issue = 0. Stall and issue follow combinationally from the inputs once reset is released.
- Hazard on source n is `i_id_rsn_used && (i_id_rsn != 0) && (cnt[i_id_rsn] > STALL_THR)`.
- o_stall = i_id_valid && !i_flush && (hazard on rs1 || hazard on rs2). Purely combinational, same cycle.
- o_issue = i_id_valid && !o_stall && !i_flush && !i_hold.
- Per-cycle update of every register r, when i_hold = 0:
  - dec = (cnt[r] == 0) ? 0 : cnt[r] - 1.
  - If o_issue && i_id_regwrite && (i_id_rd == r) && (r != 0): cnt[r] <= max(dec, i_id_lat).
  - Otherwise cnt[r] <= dec.
- When i_hold = 1: all cnt retain their values and no issue occurs. o_stall is still evaluated.
- Timing, ALU producer (lat 1): dependent in the next cycle sees cnt = 1, so no stall; it is served by the EX/MEM bypass.
- Timing, load producer (lat 2): dependent in the next cycle sees cnt = 2, so it stalls exactly one cycle. It then sees cnt = 1 and issues; it is served by the MEM/WB bypass.
- The countdown keeps decrementing during a stall, because the producer keeps advancing.
- WAW: the max() rule keeps the later-available value, so a young short-latency writer never hides an older long-latency writer.
- rd = 0 or i_id_regwrite = 0: no counter is written.
- i_id_lat = 0: no tracking; the counter still follows the max() rule, i.e. it is unchanged apart from the decrement.
- Flush in the same cycle as a hazard: o_stall = 0 and o_issue = 0; no counter is written. In-flight counters continue to decrement, because older instructions are not flushed.
- Counter saturation cannot occur: writes are bounded by the maximum value of LAT_W.
- Reset mid-operation: counters clear immediately; pending hazards are dropped.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_PERF_EN.
- Defined:
  - Adds output o_stall_cnt (32 bits), reset to 0.
  - Increments by 1 on each rising edge where o_stall = 1 and i_hold = 0.
  - Wraps from 0xFFFF_FFFF to 0.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Shared pipeline package holds:
  - REG_ADDR_W = 5 and NREG.
  - LAT_W and latency constants LAT_NONE = 0, LAT_ALU = 1, LAT_LOAD = 2.
  - typedef reg_addr_t.
- The decoder drives i_id_lat from these constants.
- One natural sub-module, scoreboard_entry: a single countdown with its decrement/max-write rule, generated NREG-1 times.
- Hazard compare and stall logic stay in the top level.

Test Plan:
- Reset release → o_busy = 0, o_stall = 0 with any ID inputs. Issue addi x5 (lat 1) → next cycle o_busy[5] = 1. Dependent add x6,x5,x5 → o_stall = 0, o_issue = 1.
- lw x7 (lat 2), then add x8,x7,x1 → exactly one cycle of o_stall = 1, then o_issue = 1. cnt[7] reads 2, then 1, then 0.
- lw x7 and dependent in ID while i_flush = 1 → o_stall = 0, o_issue = 0; cnt[7] still decrements to 0.
- WAW: mul-style write x9 with lat 3, next cycle addi x9 (lat 1) → cnt[9] = max(2,1) = 2. A reader of x9 stalls one cycle.
- Writes to x0 with lat 3, and readers of x0 → o_busy[0] = 0 and never a stall. i_hold = 1 for 3 cycles after lw x7 → cnt[7] frozen at 2, stall held.
- With HAZARD_SCOREBOARD_PERF_EN defined: three load-use pairs → o_stall_cnt = 3. A stall cycle with i_hold = 1 is not counted.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared pipeline constants for the RV32I core: register addressing and the
// producer latency codes the decoder drives into the hazard scoreboard.
package hazard_scoreboard_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREG       = 32;
  localparam int LAT_W      = 2;

  localparam logic [LAT_W-1:0] LAT_NONE = 2'd0;
  localparam logic [LAT_W-1:0] LAT_ALU  = 2'd1;
  localparam logic [LAT_W-1:0] LAT_LOAD = 2'd2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One per-register countdown: decrements toward zero every unfrozen cycle and
// takes the later of its own remaining time and a newly issued writer's latency.
module hazard_scoreboard_entry #(
  parameter int LAT_W = hazard_scoreboard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             wr_en,
  input  logic [LAT_W-1:0] wr_lat,
  output logic [LAT_W-1:0] cnt
);
  logic [LAT_W-1:0] dec;

  always_comb begin
    dec = '0;
    if (cnt != '0) dec = cnt - 1'b1;
  end

  // max() keeps an older long-latency writer visible behind a young short one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!hold) begin
      if (wr_en && (wr_lat > dec)) cnt <= wr_lat;
      else                         cnt <= dec;
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls readers of registers not yet forwardable
// by the time they reach EX. Optional stall counter: HAZARD_SCOREBOARD_PERF_EN.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREG      = hazard_scoreboard_pkg::NREG,
  parameter int LAT_W     = hazard_scoreboard_pkg::LAT_W,
  parameter int STALL_THR = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_rs1_used,
  input  logic                  i_id_rs2_used,
  input  logic [REG_ADDR_W-1:0] i_id_rd,
  input  logic                  i_id_regwrite,
  input  logic [LAT_W-1:0]      i_id_lat,
  input  logic                  i_flush,
  input  logic                  i_hold,
  output logic                  o_stall,
  output logic                  o_issue,
  output logic [NREG-1:0]       o_busy
`ifdef HAZARD_SCOREBOARD_PERF_EN
  ,
  output logic [31:0]           o_stall_cnt
`endif
);
  localparam logic [LAT_W-1:0] THR = LAT_W'(STALL_THR);

  logic [LAT_W-1:0] cnt [NREG];
  logic             haz_rs1;
  logic             haz_rs2;

  assign cnt[0]    = '0;
  assign o_busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    logic wr_en;
    assign wr_en = o_issue && i_id_regwrite && (i_id_rd == REG_ADDR_W'(r));

    hazard_scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .hold   (i_hold),
      .wr_en  (wr_en),
      .wr_lat (i_id_lat),
      .cnt    (cnt[r])
    );

    assign o_busy[r] = (cnt[r] != '0);
  end

  assign haz_rs1 = i_id_rs1_used && (i_id_rs1 != '0) && (cnt[i_id_rs1] > THR);
  assign haz_rs2 = i_id_rs2_used && (i_id_rs2 != '0) && (cnt[i_id_rs2] > THR);

  // Gating with reset keeps both pipeline controls quiet while the core is held in reset
  assign o_stall = i_rst_n && i_id_valid && !i_flush && (haz_rs1 || haz_rs2);
  assign o_issue = i_rst_n && i_id_valid && !o_stall && !i_flush && !i_hold;

`ifdef HAZARD_SCOREBOARD_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                o_stall_cnt <= '0;
    else if (o_stall && !i_hold) o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver queues hand-computed
// {stall, issue, busy} per cycle; a negedge monitor pops and compares.
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int W = 2 + 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_regwrite;
  logic [1:0]  id_lat;
  logic        flush, hold;
  logic        stall, issue;
  logic [31:0] busy;
`ifdef HAZARD_SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt;
`endif

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  hazard_scoreboard dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_rs1_used (id_rs1_used),
    .i_id_rs2_used (id_rs2_used),
    .i_id_rd       (id_rd),
    .i_id_regwrite (id_regwrite),
    .i_id_lat      (id_lat),
    .i_flush       (flush),
    .i_hold        (hold),
    .o_stall       (stall),
    .o_issue       (issue),
    .o_busy        (busy)
`ifdef HAZARD_SCOREBOARD_PERF_EN
    ,
    .o_stall_cnt   (stall_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // monitor + scoreboard
  always @(negedge clk) begin
    logic [W-1:0] exp_v;
    logic [W-1:0] got_v;
    string        nm;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {stall, issue, busy};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL %s: got stall=%0b issue=%0b busy=%h, expected stall=%0b issue=%0b busy=%h",
                 nm, got_v[33], got_v[32], got_v[31:0], exp_v[33], exp_v[32], exp_v[31:0]);
      end
    end
  end

  // driver: apply one ID cycle, queue its expected response, advance a clock
  task automatic cyc(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic rw, input logic [1:0] lat,
                     input logic fl, input logic hd,
                     input logic es, input logic ei, input logic [31:0] eb,
                     input string nm);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs1_used = u1;
    id_rs2      = rs2;
    id_rs2_used = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_lat      = lat;
    flush       = fl;
    hold        = hd;
    exp_q.push_back({es, ei, eb});
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input logic [31:0] eb, input string nm);
    cyc(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, LAT_NONE, 1'b0, 1'b0, 1'b0, 1'b0, eb, nm);
  endtask

  function automatic logic [31:0] bit_of(input int r);
    logic [31:0] m;
    m = 32'd0;
    m[r] = 1'b1;
    return m;
  endfunction

  initial begin
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    // in reset with a hazard-looking instruction present
    cyc(1, 5'd5, 1, 5'd5, 1, 5'd5, 1, LAT_LOAD, 0, 0, 0, 0, 32'd0, "reset_a");
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd7, 1, 2'd3,     0, 0, 0, 0, 32'd0, "reset_b");
    rst_n = 1'b1;

    // ALU producer then dependent
    cyc(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, LAT_ALU, 0, 0, 0, 1, 32'd0,      "addi_x5");
    cyc(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, LAT_ALU, 0, 0, 0, 1, bit_of(5),  "alu_dep_no_stall");
    nop(bit_of(6), "x6_busy");

    // load-use: exactly one stall cycle
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, LAT_LOAD, 0, 0, 0, 1, 32'd0,     "lw_x7");
    cyc(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, LAT_ALU,  0, 0, 1, 0, bit_of(7), "load_use_stall");
    cyc(1, 5'd7, 1, 5'd1, 1, 5'd8, 1, LAT_ALU,  0, 0, 0, 1, bit_of(7), "load_use_issue");
    nop(bit_of(8), "x8_busy");

    // flush on a hazard cycle
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, LAT_LOAD, 0, 0, 0, 1, 32'd0,     "lw_x7_flush");
    cyc(1, 5'd7, 1, 5'd7, 1, 5'd8, 1, LAT_ALU,  1, 0, 0, 0, bit_of(7), "flush_kills");
    nop(bit_of(7), "flush_x7_decays");
    nop(32'd0,     "flush_x7_clear");

    // WAW: lat 3 then lat 1 to the same register
    cyc(1, 5'd1, 1, 5'd2, 1, 5'd9,  1, 2'd3,    0, 0, 0, 1, 32'd0,     "mul_x9");
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd9,  1, LAT_ALU, 0, 0, 0, 1, bit_of(9), "addi_x9_waw");
    cyc(1, 5'd9, 1, 5'd0, 1, 5'd10, 1, LAT_ALU, 0, 0, 1, 0, bit_of(9), "waw_reader_stall");
    cyc(1, 5'd9, 1, 5'd0, 1, 5'd10, 1, LAT_ALU, 0, 0, 0, 1, bit_of(9), "waw_reader_issue");
    nop(bit_of(10), "x10_busy");

    // x0 is never tracked; lat 0 is never tracked
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd0,  1, 2'd3,     0, 0, 0, 1, 32'd0, "write_x0");
    cyc(1, 5'd0, 1, 5'd0, 1, 5'd11, 1, LAT_NONE, 0, 0, 0, 1, 32'd0, "read_x0");
    nop(32'd0, "x0_lat0_idle");

    // hold freezes the countdown while stall is still reported
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd7, 1, LAT_LOAD, 0, 0, 0, 1, 32'd0,     "lw_x7_hold");
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, LAT_ALU,  0, 1, 1, 0, bit_of(7), "hold_1");
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, LAT_ALU,  0, 1, 1, 0, bit_of(7), "hold_2");
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, LAT_ALU,  0, 1, 1, 0, bit_of(7), "hold_3");
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, LAT_ALU,  0, 0, 1, 0, bit_of(7), "after_hold_stall");
    cyc(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, LAT_ALU,  0, 0, 0, 1, bit_of(7), "after_hold_issue");
    nop(bit_of(8), "x8_busy_again");
`ifdef HAZARD_SCOREBOARD_PERF_EN
    checks++;
    if (stall_cnt !== 32'd3) begin
      errors++;
      $display("FAIL perf_count: got %0d, expected 3", stall_cnt);
    end
`endif

    // unused sources never stall
    cyc(1, 5'd1,  1, 5'd0,  0, 5'd12, 1, LAT_LOAD, 0, 0, 0, 1, 32'd0,      "lw_x12");
    cyc(1, 5'd12, 0, 5'd12, 0, 5'd0,  0, LAT_NONE, 0, 0, 0, 1, bit_of(12), "unused_src");

    // reset mid-operation drops pending hazards
    cyc(1, 5'd1, 1, 5'd0, 0, 5'd13, 1, LAT_LOAD, 0, 0, 0, 1, bit_of(12), "lw_x13");
    rst_n = 1'b0;
    cyc(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, LAT_ALU, 0, 0, 0, 0, 32'd0, "mid_reset");
    rst_n = 1'b1;
`ifdef HAZARD_SCOREBOARD_PERF_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL perf_reset: got %0d, expected 0", stall_cnt);
    end
`endif
    cyc(1, 5'd13, 1, 5'd0, 0, 5'd14, 1, LAT_ALU, 0, 0, 0, 1, 32'd0, "post_reset_issue");
    nop(bit_of(14), "x14_busy");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
